external_sm_bin_to_bcd: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that sits

---
 rtl/external_sm_bin_to_bcd.sv | 109 ++++++++++
 tb/tb_external_sm_bin_to_bcd.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/external_sm_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter feeding the 3-digit hex display.
// Optional macro SM_BCD_OVF_MARK_EN: show FFF instead of 999 on overflow.
module external_sm_bin_to_bcd #(
    parameter int BIN_W = 10
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       digit_1,
    output logic [3:0]       digit_2,
    output logic [3:0]       digit_3
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

`ifdef SM_BCD_OVF_MARK_EN
    localparam logic [3:0] OVF_DIGIT = 4'hF;
`else
    localparam logic [3:0] OVF_DIGIT = 4'd9;
`endif

    logic [1:0]       state;
    logic [BIN_W-1:0] shift_reg;
    logic [15:0]      acc;
    logic [15:0]      acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_nxt;
    logic [15:0]      bin_ext;
    logic             accept;
    logic             ovf_res;

    assign bin_ext = 16'(bin_in);
    assign busy    = (state != S_IDLE);
    // A start on the done cycle lands in IDLE but must still be dropped.
    assign accept  = (state == S_IDLE) && start && !done;
    // A nonzero thousands digit can only come from a value above 999.
    assign ovf_res = ovf_nxt | (|acc_adj[15:12]);

    // Add-3 correction applied to every digit >= 5 before each shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM; digits and ovf update only when a result completes.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf_nxt   <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            digit_1   <= 4'd0;
            digit_2   <= 4'd0;
            digit_3   <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        shift_reg <= bin_in;
                        acc       <= '0;
                        cnt       <= CNT_W'(BIN_W);
                        ovf_nxt   <= (bin_ext > 16'd999);
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc       <= {acc_adj[14:0], shift_reg[BIN_W-1]};
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (ovf_res) begin
                        digit_1 <= OVF_DIGIT;
                        digit_2 <= OVF_DIGIT;
                        digit_3 <= OVF_DIGIT;
                    end else begin
                        digit_1 <= acc[3:0];
                        digit_2 <= acc[7:4];
                        digit_3 <= acc[11:8];
                    end
                    ovf   <= ovf_res;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_external_sm_bin_to_bcd.sv
// Self-checking bench for external_sm_bin_to_bcd.
// Honours SM_BCD_OVF_MARK_EN for the expected overflow digits.
module tb_external_sm_bin_to_bcd;

    localparam int BIN_W = 10;

`ifdef SM_BCD_OVF_MARK_EN
    localparam logic [3:0] OD = 4'hF;
`else
    localparam logic [3:0] OD = 4'd9;
`endif

    logic             clk;
    logic             rst;
    logic [BIN_W-1:0] bin_in;
    logic             start;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       digit_1;
    logic [3:0]       digit_2;
    logic [3:0]       digit_3;

    int errors = 0;
    int checks = 0;

    external_sm_bin_to_bcd #(.BIN_W(BIN_W)) dut (
        .clkIn   (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .digit_1 (digit_1),
        .digit_2 (digit_2),
        .digit_3 (digit_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] val;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic       ov;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: plain decimal split, with the overflow replacement.
    function automatic logic [12:0] model(input int v);
        if (v > 999)
            return {1'b1, OD, OD, OD};
        return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [12:0] outs();
        return {ovf, digit_3, digit_2, digit_1};
    endfunction

    // Start a conversion, check latency, output hold and busy, then result.
    task automatic convert(input string name, input int v,
                           input logic [12:0] exp_r);
        logic [12:0] prev;
        int cyc;
        bit held;
        prev = outs();
        @(negedge clk);
        bin_in = 10'(v);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 10'($urandom_range(0, 1023));
        cyc  = 0;
        held = 1'b1;
        while (!done && cyc < 40) begin
            if (outs() !== prev || !busy) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, cyc, 11);
        chk({name, " hold"}, int'(held), 1);
        chk({name, " result"}, int'(outs()), int'(exp_r));
        @(negedge clk);
        chk({name, " done pulse"}, int'(done), 0);
    endtask

    initial begin
        int ndone;
        int v;

        tbl[0]  = '{val: 10'd0,    d3: 4'd0, d2: 4'd0, d1: 4'd0, ov: 1'b0};
        tbl[1]  = '{val: 10'd1,    d3: 4'd0, d2: 4'd0, d1: 4'd1, ov: 1'b0};
        tbl[2]  = '{val: 10'd9,    d3: 4'd0, d2: 4'd0, d1: 4'd9, ov: 1'b0};
        tbl[3]  = '{val: 10'd10,   d3: 4'd0, d2: 4'd1, d1: 4'd0, ov: 1'b0};
        tbl[4]  = '{val: 10'd99,   d3: 4'd0, d2: 4'd9, d1: 4'd9, ov: 1'b0};
        tbl[5]  = '{val: 10'd100,  d3: 4'd1, d2: 4'd0, d1: 4'd0, ov: 1'b0};
        tbl[6]  = '{val: 10'd255,  d3: 4'd2, d2: 4'd5, d1: 4'd5, ov: 1'b0};
        tbl[7]  = '{val: 10'd999,  d3: 4'd9, d2: 4'd9, d1: 4'd9, ov: 1'b0};
        tbl[8]  = '{val: 10'd0,    d3: 4'd0, d2: 4'd0, d1: 4'd0, ov: 1'b0};
        tbl[9]  = '{val: 10'd1000, d3: OD,   d2: OD,   d1: OD,   ov: 1'b1};
        tbl[10] = '{val: 10'd1023, d3: OD,   d2: OD,   d1: OD,   ov: 1'b1};
        tbl[11] = '{val: 10'd512,  d3: 4'd5, d2: 4'd1, d1: 4'd2, ov: 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset outs", int'(outs()), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            convert($sformatf("tbl%0d", i), int'(tbl[i].val),
                    {tbl[i].ov, tbl[i].d3, tbl[i].d2, tbl[i].d1});
        end

        // start with 700 mid-conversion and on the done cycle is dropped
        @(negedge clk);
        bin_in = 10'd42;
        start  = 1'b1;
        ndone  = 0;
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) begin
                start  = 1'b1;
                bin_in = 10'd700;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    start  = 1'b1;
                    bin_in = 10'd700;
                end
            end
            if (c == 14) chk("ignore busy", int'(busy), 0);
        end
        chk("ignore ndone", ndone, 1);
        chk("ignore result", int'(outs()), int'(model(42)));

        // reset mid-conversion aborts with no done
        @(negedge clk);
        bin_in = 10'd512;
        start  = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done) + ndone, 0);
        chk("abort outs", int'(outs()), 0);
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no late done", ndone, 0);
        convert("after abort", 7, model(7));

        // random values against the decimal reference
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 1023));
            convert($sformatf("rand %0d", v), v, model(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
